// File: rtl/morra_pkg.sv
// Shared types and helpers for the MorraCinese match driver.
// Contents:
//   move_t       player move encoding (00 = no move)
//   res_t        referee MANCHE/PARTITA encoding
//   drv_state_t  driver FSM states
//   beats()      true when move a wins against move b
//   rotate()     sasso -> carta -> forbice -> sasso
//   pick_move()  legal move from two random bits and the player's last winning move
//   sat_inc()    counter increment that holds at the maximum value
package morra_pkg;

    typedef enum logic [1:0] {
        NOMOVE  = 2'b00,
        SASSO   = 2'b01,
        CARTA   = 2'b10,
        FORBICE = 2'b11
    } move_t;

    typedef enum logic [1:0] {
        INVALID = 2'b00,
        G1WIN   = 2'b01,
        G2WIN   = 2'b10,
        DRAW    = 2'b11
    } res_t;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        GAP,
        PLAY,
        CHECK,
        DONE,
        ERROR
    } drv_state_t;

    localparam int              CNT_W   = 5;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic beats(input move_t a, input move_t b);
        return (a == SASSO && b == FORBICE) ||
               (a == CARTA && b == SASSO)   ||
               (a == FORBICE && b == CARTA);
    endfunction

    function automatic move_t rotate(input move_t m);
        move_t r;
        case (m)
            SASSO:   r = CARTA;
            CARTA:   r = FORBICE;
            default: r = SASSO;
        endcase
        return r;
    endfunction

    // The referee forbids a player from repeating the move it just won with,
    // so a candidate equal to that move is bumped to the next one.
    function automatic move_t pick_move(input logic [1:0] bits, input move_t last_win);
        move_t m;
        m = (bits == 2'b00) ? SASSO : move_t'(bits);
        if (m == last_win) begin
            m = rotate(m);
        end
        return m;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/morra_move_lfsr.sv
// 8-bit Galois LFSR (x^8+x^6+x^5+x^4+1) used as the move source for both players.
// Ports:
//   clk     in   clock
//   rst_n   in   asynchronous active-low reset, loads SEED
//   en      in   advance one step
//   bits_a  out  2-bit random field for player 1
//   bits_b  out  2-bit random field for player 2
module morra_move_lfsr #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic [1:0] bits_a,
    output logic [1:0] bits_b
);

    logic [7:0] lfsr;

    // Right-shifting Galois form; 8'hB8 holds the x^8, x^6, x^5, x^4 feedback taps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= SEED;
        end else if (en) begin
            lfsr <= {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
        end
    end

    assign bits_a = lfsr[1:0];
    assign bits_b = lfsr[3:2];

endmodule

// File: rtl/morra_match_driver.sv
// Automated two-player initiator for the MorraCinese referee. Configures a
// match, plays legal random moves for both players, mirrors the referee's
// scoring and reports the final result.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | after reset, waiting for start
// SETUP | INIZIA high, round code on PRIMO/SECONDO, SETUP_CYCLES cycles
// GAP   | one cycle of INIZIA low and no moves before the first manche
// PLAY  | both moves driven for one cycle
// CHECK | moves idle, referee reply sampled, scoreboard updated
// DONE  | match over, result held until next start
// ERROR | too many consecutive invalid replies, error held until next start
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               begin a match (accepted in IDLE, DONE, ERROR)
//   cfg_rounds[3:0]     extra manches beyond the minimum of four
//   MANCHE[1:0]         referee manche result
//   PARTITA[1:0]        referee match result, 00 while ongoing
//   INIZIA              referee setup request
//   PRIMO/SECONDO[1:0]  player moves, round code during SETUP
//   busy, done, error   status (done is a one-cycle pulse)
//   result[1:0]         final PARTITA, 00 until DONE
//   manche_cnt, g1_wins, g2_wins [4:0]  saturating scoreboard
module morra_match_driver
    import morra_pkg::*;
#(
    parameter int         SETUP_CYCLES  = 2,
    parameter int         INVALID_LIMIT = 3,
    parameter logic [7:0] SEED          = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] cfg_rounds,
    input  logic [1:0] MANCHE,
    input  logic [1:0] PARTITA,
    output logic       INIZIA,
    output logic [1:0] PRIMO,
    output logic [1:0] SECONDO,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] result,
    output logic [4:0] manche_cnt,
    output logic [4:0] g1_wins,
    output logic [4:0] g2_wins
);

    localparam int SC_W  = (SETUP_CYCLES > 2) ? $clog2(SETUP_CYCLES) : 1;
    localparam int INV_W = $clog2(INVALID_LIMIT + 1);

    drv_state_t       state;
    logic [SC_W-1:0]  setup_cnt;
    logic [INV_W-1:0] inv_cnt;
    logic [INV_W-1:0] inv_inc;
    move_t            last_win1;
    move_t            last_win2;
    move_t            played1;
    move_t            played2;
    move_t            nxt_win1;
    move_t            nxt_win2;
    move_t            cand1;
    move_t            cand2;
    res_t             reply;
    logic             lfsr_en;
    logic [1:0]       rnd1;
    logic [1:0]       rnd2;

    morra_move_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (lfsr_en),
        .bits_a (rnd1),
        .bits_b (rnd2)
    );

    assign lfsr_en = (state == PLAY);
    assign reply   = res_t'(MANCHE);
    assign inv_inc = inv_cnt + 1'b1;

    // Candidates for the next PLAY must respect the reply being absorbed in
    // this same CHECK cycle, so they are built from the post-update shadow.
    always_comb begin
        nxt_win1 = last_win1;
        nxt_win2 = last_win2;
        if (state == CHECK) begin
            case (reply)
                G1WIN: begin
                    nxt_win1 = played1;
                    nxt_win2 = NOMOVE;
                end
                G2WIN: begin
                    nxt_win1 = NOMOVE;
                    nxt_win2 = played2;
                end
                DRAW: begin
                    nxt_win1 = NOMOVE;
                    nxt_win2 = NOMOVE;
                end
                default: ;
            endcase
        end
        cand1 = pick_move(rnd1, nxt_win1);
        cand2 = pick_move(rnd2, nxt_win2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            setup_cnt  <= '0;
            inv_cnt    <= '0;
            last_win1  <= NOMOVE;
            last_win2  <= NOMOVE;
            played1    <= NOMOVE;
            played2    <= NOMOVE;
            INIZIA     <= 1'b0;
            PRIMO      <= 2'b00;
            SECONDO    <= 2'b00;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            result     <= 2'b00;
            manche_cnt <= '0;
            g1_wins    <= '0;
            g2_wins    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state      <= SETUP;
                        setup_cnt  <= SC_W'(SETUP_CYCLES - 1);
                        INIZIA     <= 1'b1;
                        PRIMO      <= cfg_rounds[3:2];
                        SECONDO    <= cfg_rounds[1:0];
                        busy       <= 1'b1;
                        error      <= 1'b0;
                        result     <= 2'b00;
                        manche_cnt <= '0;
                        g1_wins    <= '0;
                        g2_wins    <= '0;
                        inv_cnt    <= '0;
                        last_win1  <= NOMOVE;
                        last_win2  <= NOMOVE;
                    end
                end
                SETUP: begin
                    if (setup_cnt == '0) begin
                        state   <= GAP;
                        INIZIA  <= 1'b0;
                        PRIMO   <= 2'b00;
                        SECONDO <= 2'b00;
                    end else begin
                        setup_cnt <= setup_cnt - 1'b1;
                    end
                end
                GAP: begin
                    state   <= PLAY;
                    PRIMO   <= cand1;
                    SECONDO <= cand2;
                    played1 <= cand1;
                    played2 <= cand2;
                end
                PLAY: begin
                    state   <= CHECK;
                    PRIMO   <= 2'b00;
                    SECONDO <= 2'b00;
                end
                CHECK: begin
                    last_win1 <= nxt_win1;
                    last_win2 <= nxt_win2;
                    if (reply == INVALID) begin
                        inv_cnt <= inv_inc;
                    end else begin
                        inv_cnt    <= '0;
                        manche_cnt <= sat_inc(manche_cnt);
                        if (reply == G1WIN) begin
                            g1_wins <= sat_inc(g1_wins);
                        end
                        if (reply == G2WIN) begin
                            g2_wins <= sat_inc(g2_wins);
                        end
                    end

                    if (reply == INVALID && inv_inc == INV_W'(INVALID_LIMIT)) begin
                        state <= ERROR;
                        busy  <= 1'b0;
                        error <= 1'b1;
                    end else if (PARTITA != 2'b00) begin
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= PARTITA;
                    end else begin
                        state   <= PLAY;
                        PRIMO   <= cand1;
                        SECONDO <= cand2;
                        played1 <= cand1;
                        played2 <= cand2;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_morra_match_driver.sv
// Bench for morra_match_driver: a behavioural referee (real rules or forced
// replies) drives MANCHE/PARTITA; the driver's scoreboard and status are
// compared against the referee's own tallies.
module tb_morra_match_driver;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] cfg_rounds;
    logic [1:0] MANCHE;
    logic [1:0] PARTITA;
    logic       INIZIA;
    logic [1:0] PRIMO;
    logic [1:0] SECONDO;
    logic       busy;
    logic       done;
    logic       error;
    logic [1:0] result;
    logic [4:0] manche_cnt;
    logic [4:0] g1_wins;
    logic [4:0] g2_wins;

    int checks;
    int errors;

    morra_match_driver dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cfg_rounds (cfg_rounds),
        .MANCHE     (MANCHE),
        .PARTITA    (PARTITA),
        .INIZIA     (INIZIA),
        .PRIMO      (PRIMO),
        .SECONDO    (SECONDO),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .result     (result),
        .manche_cnt (manche_cnt),
        .g1_wins    (g1_wins),
        .g2_wins    (g2_wins)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- referee model ----------------
    int         r_max, r_n, r_g1, r_g2, r_inv;
    int         r_fn, r_fg1, r_fg2;
    logic [1:0] r_lw1, r_lw2;
    bit         force_mode;
    logic [1:0] force_m, force_p;

    function automatic bit wins(input logic [1:0] a, input logic [1:0] b);
        return (a == 2'b01 && b == 2'b11) || (a == 2'b10 && b == 2'b01) ||
               (a == 2'b11 && b == 2'b10);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            MANCHE <= 2'b00; PARTITA <= 2'b00;
            r_n = 0; r_g1 = 0; r_g2 = 0; r_lw1 = 2'b00; r_lw2 = 2'b00;
            r_fn = 0; r_fg1 = 0; r_fg2 = 0; r_max = 4;
        end else if (INIZIA) begin
            r_max = int'({PRIMO, SECONDO}) + 4;
            r_n = 0; r_g1 = 0; r_g2 = 0; r_lw1 = 2'b00; r_lw2 = 2'b00;
            r_fn = 0; r_fg1 = 0; r_fg2 = 0;
            MANCHE <= 2'b00; PARTITA <= 2'b00;
        end else if (PRIMO != 2'b00 && SECONDO != 2'b00 && PARTITA == 2'b00) begin
            if (force_mode) begin
                MANCHE  <= force_m;
                PARTITA <= force_p;
                if (force_m != 2'b00) r_fn++;
                if (force_m == 2'b01) r_fg1++;
                if (force_m == 2'b10) r_fg2++;
            end else if ((r_lw1 != 2'b00 && PRIMO == r_lw1) ||
                         (r_lw2 != 2'b00 && SECONDO == r_lw2)) begin
                MANCHE <= 2'b00;
                r_inv++;
            end else begin
                r_n++;
                if (PRIMO == SECONDO) begin
                    MANCHE <= 2'b11; r_lw1 = 2'b00; r_lw2 = 2'b00;
                end else if (wins(PRIMO, SECONDO)) begin
                    MANCHE <= 2'b01; r_g1++; r_lw1 = PRIMO; r_lw2 = 2'b00;
                end else begin
                    MANCHE <= 2'b10; r_g2++; r_lw1 = 2'b00; r_lw2 = SECONDO;
                end
                if ((r_n >= 4 && (r_g1 - r_g2 >= 2 || r_g2 - r_g1 >= 2)) || r_n >= r_max)
                    PARTITA <= (r_g1 > r_g2) ? 2'b01 : (r_g2 > r_g1) ? 2'b10 : 2'b11;
            end
        end else begin
            MANCHE <= 2'b00;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic [3:0] cfg);
        cfg_rounds = cfg;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns at a negedge inside a PLAY cycle (stays put if already there).
    task automatic wait_play();
        int n = 0;
        while (!(INIZIA == 1'b0 && PRIMO != 2'b00) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("play_reached", (INIZIA == 1'b0 && PRIMO != 2'b00), 1);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_in_budget", done === 1'b1, 1);
    endtask

    task automatic match_end_checks();
        check("result_eq_partita", result, PARTITA);
        check("manche_cnt_model", manche_cnt, r_n);
        check("g1_model", g1_wins, r_g1);
        check("g2_model", g2_wins, r_g2);
        check("busy_after_done", busy, 0);
        check("wins_le_manches", (32'(g1_wins) + 32'(g2_wins)) <= 32'(manche_cnt), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [1:0] pat [7];
    int         consec;
    int         inv_base;
    int         cfg_i;
    bit         found;

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0; start = 1'b0; cfg_rounds = 4'd0;
        force_mode = 1'b0; force_m = 2'b11; force_p = 2'b00; r_inv = 0;
        repeat (3) @(negedge clk);

        // reset values
        check("rst_inizia", INIZIA, 0);
        check("rst_primo", PRIMO, 0);
        check("rst_secondo", SECONDO, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_result", result, 0);
        check("rst_manche", manche_cnt, 0);
        check("rst_g1", g1_wins, 0);
        check("rst_g2", g2_wins, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // setup sequence with cfg_rounds = 0010
        pulse_start(4'b0010);
        check("setup1_inizia", INIZIA, 1);
        check("setup1_primo", PRIMO, 2'b00);
        check("setup1_secondo", SECONDO, 2'b10);
        check("setup1_busy", busy, 1);
        @(negedge clk);
        check("setup2_inizia", INIZIA, 1);
        check("setup2_secondo", SECONDO, 2'b10);
        @(negedge clk);
        check("gap_inizia", INIZIA, 0);
        check("gap_primo", PRIMO, 0);
        check("gap_secondo", SECONDO, 0);
        @(negedge clk);
        check("play1_primo_move", PRIMO != 2'b00, 1);
        check("play1_secondo_move", SECONDO != 2'b00, 1);

        // start while busy is ignored
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_start_inizia", INIZIA, 0);
        check("busy_start_busy", busy, 1);
        wait_done(20);
        match_end_checks();
        check("real_match_no_invalid", r_inv, 0);
        @(negedge clk);
        check("done_one_pulse", done, 0);
        check("result_held", result, PARTITA);

        // start in DONE clears result; forced referee from here
        force_mode = 1'b1; force_m = 2'b11; force_p = 2'b00;
        pulse_start(4'd0);
        check("restart_result", result, 0);
        check("restart_inizia", INIZIA, 1);
        check("restart_manche", manche_cnt, 0);

        // a G1 win with forbice forbids forbice on the next PLAY
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            wait_play();
            if (PRIMO == 2'b11) found = 1'b1;
            else @(negedge clk);
        end
        check("forbice_seen", found, 1);
        force_m = 2'b01;
        @(negedge clk);
        force_m = 2'b11;
        @(negedge clk);
        check("after_win_in_play", (INIZIA == 1'b0 && PRIMO != 2'b00), 1);
        check("no_repeat_forbice", PRIMO != 2'b11, 1);
        check("g1_after_win", g1_wins, r_fg1);

        // saturation of manche_cnt with forced draws
        for (int i = 0; i < 40; i++) begin
            wait_play();
            @(negedge clk);
        end
        wait_play();
        check("manche_saturated", manche_cnt, (r_fn > 31) ? 31 : r_fn);
        check("g1_after_sat", g1_wins, r_fg1);
        force_p = 2'b01;
        @(negedge clk);
        force_p = 2'b00;
        @(negedge clk);
        check("sat_done", done, 1);
        check("sat_result", result, 2'b01);
        check("sat_manche_hold", manche_cnt, 31);

        // valid manche and match end in the same CHECK
        cfg_i = $urandom_range(0, 15);
        pulse_start(4'(cfg_i));
        force_m = 2'b11;
        wait_play();
        @(negedge clk);
        wait_play();
        force_m = 2'b10; force_p = 2'b10;
        @(negedge clk);
        force_m = 2'b11; force_p = 2'b00;
        @(negedge clk);
        check("simul_done", done, 1);
        check("simul_result", result, 2'b10);
        check("simul_manche", manche_cnt, r_fn);
        check("simul_g2", g2_wins, r_fg2);

        // consecutive invalid replies; a valid one in between clears the run
        pat = '{2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00};
        pulse_start(4'd0);
        consec = 0;
        for (int i = 0; i < 7; i++) begin
            wait_play();
            force_m = pat[i];
            @(negedge clk);
            @(negedge clk);
            consec = (pat[i] == 2'b00) ? consec + 1 : 0;
            check("inv_error", error, consec >= 3);
            check("inv_busy", busy, consec < 3);
            check("inv_manche", manche_cnt, r_fn);
        end
        force_m = 2'b11;

        // restart from ERROR, then asynchronous reset in the middle of PLAY
        force_mode = 1'b0;
        pulse_start(4'd0);
        check("err_cleared", error, 0);
        check("err_restart_busy", busy, 1);
        wait_play();
        @(negedge clk);
        wait_play();
        rst_n = 1'b0;
        #2;
        check("arst_inizia", INIZIA, 0);
        check("arst_primo", PRIMO, 0);
        check("arst_secondo", SECONDO, 0);
        check("arst_busy", busy, 0);
        check("arst_manche", manche_cnt, 0);
        @(negedge clk);
        check("arst_hold_primo", PRIMO, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // random matches against the real referee
        inv_base = r_inv;
        for (int m = 0; m < 240; m++) begin
            cfg_i = (m < 200) ? 0 : int'($urandom_range(0, 15));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            pulse_start(4'(cfg_i));
            @(negedge clk);
            @(negedge clk);
            wait_done(2 * (4 + cfg_i) + 4);
            match_end_checks();
            check("manche_le_max", 32'(manche_cnt) <= 32'(4 + cfg_i), 1);
        end
        check("random_no_invalid", r_inv, inv_base);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
